icache_refill_ctrl: RTL and testbench

Refill sequencer for the vanilla core instruction cache. On a miss it issues one remote word-read per instruction in the missing block and collects the responses, which may return in any order. It writes the words into the icache strictly in block-offset order 0..N-1, because the icache write port requires in-sequence writes. It sits between the core's miss/PC logic, the remote-load request path, and the icache write port (`v_i`/`w_i`/`w_pc_i`/`w_instr_i`).

---
 rtl/bsg_vanilla_pkg.sv | 19 +
 rtl/icache_refill_buffer.sv | 44 ++++
 rtl/icache_refill_ctrl.sv | 170 +++++++++++++++++
 tb/tb_icache_refill_ctrl.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bsg_vanilla_pkg.sv
// rtl/bsg_vanilla_pkg.sv - shared types for the vanilla core icache refill path
package bsg_vanilla_pkg;

  // Width of the counter fields in the refill debug view; wide enough for any block size in use.
  localparam int icache_refill_dbg_cnt_width_gp = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    FILL = 2'd2
  } icache_refill_state_e;

  typedef struct packed {
    icache_refill_state_e                        state;
    logic [icache_refill_dbg_cnt_width_gp-1:0]   req_cnt;
    logic [icache_refill_dbg_cnt_width_gp-1:0]   wr_ptr;
  } icache_refill_dbg_s;

endpackage

// File: rtl/icache_refill_buffer.sv
// rtl/icache_refill_buffer.sv - per-block word buffer with valid bits for out-of-order refill responses
module icache_refill_buffer #(
  parameter  int block_size_p     = 4,
  localparam int offset_width_lp  = $clog2(block_size_p)
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       clear,
  input  logic                       wr_v,
  input  logic [offset_width_lp-1:0] wr_offset,
  input  logic [31:0]                wr_data,
  input  logic [offset_width_lp-1:0] rd_offset,
  output logic                       wr_hit,
  output logic                       rd_v,
  output logic [31:0]                rd_data
);

  logic [block_size_p-1:0] valid_q;
  logic [31:0]             data_q [block_size_p];

  // Valid bits: wiped when a new block starts, set as each response is captured.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= '0;
    end else if (clear) begin
      valid_q <= '0;
    end else if (wr_v) begin
      valid_q[wr_offset] <= 1'b1;
    end
  end

  // Data words need no reset; they are only consumed behind a set valid bit.
  always_ff @(posedge clk) begin
    if (wr_v) begin
      data_q[wr_offset] <= wr_data;
    end
  end

  // The read side sees only registered contents, so a same-cycle capture is not bypassed.
  assign wr_hit  = valid_q[wr_offset];
  assign rd_v    = valid_q[rd_offset];
  assign rd_data = data_q[rd_offset];

endmodule

// File: rtl/icache_refill_ctrl.sv
// rtl/icache_refill_ctrl.sv - icache miss refill sequencer (option: ICACHE_REFILL_CRITICAL_WORD_FIRST_EN)
module icache_refill_ctrl
  import bsg_vanilla_pkg::*;
#(
  parameter  int icache_tag_width_p           = 6,
  parameter  int icache_entries_p             = 16,
  parameter  int icache_block_size_in_words_p = 4,
  localparam int pc_width_lp           = icache_tag_width_p + $clog2(icache_entries_p),
  localparam int block_offset_width_lp = $clog2(icache_block_size_in_words_p)
) (
  input  logic                             clk_i,
  input  logic                             reset_i,
  input  logic                             miss_v_i,
  input  logic [pc_width_lp-1:0]           miss_pc_i,
  output logic                             miss_ready_o,
  output logic                             req_v_o,
  output logic [pc_width_lp-1:0]           req_addr_o,
  input  logic                             req_ready_i,
  input  logic                             resp_v_i,
  input  logic [block_offset_width_lp-1:0] resp_offset_i,
  input  logic [31:0]                      resp_data_i,
  output logic                             icache_v_o,
  output logic [pc_width_lp-1:0]           icache_w_pc_o,
  output logic [31:0]                      icache_w_instr_o,
  output logic                             refill_done_o,
  output logic                             err_o
);

  localparam int base_width_lp = pc_width_lp - block_offset_width_lp;
  localparam logic [block_offset_width_lp-1:0] last_off_lp =
    block_offset_width_lp'(icache_block_size_in_words_p - 1);
  localparam logic [block_offset_width_lp-1:0] one_lp = block_offset_width_lp'(1);

  icache_refill_state_e state_q, state_n;

  logic [base_width_lp-1:0]         base_q;
  logic [block_offset_width_lp-1:0] req_cnt_q;
  logic [block_offset_width_lp-1:0] wr_ptr_q;
  logic [block_offset_width_lp-1:0] req_off;
  logic                             err_q;

  logic        busy;
  logic        accept;
  logic        req_fire;
  logic        resp_take;
  logic        resp_bad;
  logic        wr_fire;
  logic        last_wr;
  logic        buf_hit;
  logic        buf_rd_v;
  logic [31:0] buf_rd_data;

  assign busy      = (state_q != IDLE);
  assign accept    = miss_v_i & (state_q == IDLE);
  assign req_fire  = (state_q == REQ) & req_ready_i;
  assign resp_take = resp_v_i & busy & ~buf_hit;
  assign resp_bad  = resp_v_i & (~busy | buf_hit);
  assign wr_fire   = busy & buf_rd_v;
  assign last_wr   = wr_fire & (wr_ptr_q == last_off_lp);

`ifdef ICACHE_REFILL_CRITICAL_WORD_FIRST_EN
  logic [block_offset_width_lp-1:0] miss_off_q;

  // Remember where the missing word sits so requests start there and wrap around the block.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      miss_off_q <= '0;
    end else if (accept) begin
      miss_off_q <= miss_pc_i[block_offset_width_lp-1:0];
    end
  end

  assign req_off = miss_off_q + req_cnt_q;
`else
  logic miss_off_unused;
  assign miss_off_unused = ^miss_pc_i[block_offset_width_lp-1:0];
  assign req_off         = req_cnt_q;
`endif

  icache_refill_buffer #(
    .block_size_p (icache_block_size_in_words_p)
  ) buffer (
    .clk       (clk_i),
    .reset_n   (reset_i),
    .clear     (accept),
    .wr_v      (resp_take),
    .wr_offset (resp_offset_i),
    .wr_data   (resp_data_i),
    .rd_offset (wr_ptr_q),
    .wr_hit    (buf_hit),
    .rd_v      (buf_rd_v),
    .rd_data   (buf_rd_data)
  );

  // State register.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_n;
    end
  end

  // Next state and handshake outputs; finishing the last write always returns to IDLE,
  // including the corner where it coincides with the final request being accepted.
  always_comb begin
    state_n      = state_q;
    miss_ready_o = 1'b0;
    req_v_o      = 1'b0;
    unique case (state_q)
      IDLE: begin
        miss_ready_o = 1'b1;
        if (miss_v_i) begin
          state_n = REQ;
        end
      end
      REQ: begin
        req_v_o = 1'b1;
        if (last_wr) begin
          state_n = IDLE;
        end else if (req_fire && (req_cnt_q == last_off_lp)) begin
          state_n = FILL;
        end
      end
      FILL: begin
        if (last_wr) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Block base and the request/write counters.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      base_q    <= '0;
      req_cnt_q <= '0;
      wr_ptr_q  <= '0;
    end else if (accept) begin
      base_q    <= miss_pc_i[pc_width_lp-1:block_offset_width_lp];
      req_cnt_q <= '0;
      wr_ptr_q  <= '0;
    end else begin
      if (req_fire) begin
        req_cnt_q <= req_cnt_q + one_lp;
      end
      if (wr_fire) begin
        wr_ptr_q <= wr_ptr_q + one_lp;
      end
    end
  end

  // Sticky error for responses that arrive while idle or repeat an offset already held.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      err_q <= 1'b0;
    end else if (resp_bad) begin
      err_q <= 1'b1;
    end
  end

  assign req_addr_o       = {base_q, req_off};
  assign icache_v_o       = wr_fire;
  assign icache_w_pc_o    = {base_q, wr_ptr_q};
  assign icache_w_instr_o = buf_rd_data;
  assign refill_done_o    = last_wr;
  assign err_o            = err_q;

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// tb/tb_icache_refill_ctrl.sv - directed table and sequence bench for icache_refill_ctrl
module tb_icache_refill_ctrl;

  logic        clk;
  logic        reset_i;
  logic        miss_v_i;
  logic [9:0]  miss_pc_i;
  logic        miss_ready_o;
  logic        req_v_o;
  logic [9:0]  req_addr_o;
  logic        req_ready_i;
  logic        resp_v_i;
  logic [1:0]  resp_offset_i;
  logic [31:0] resp_data_i;
  logic        icache_v_o;
  logic [9:0]  icache_w_pc_o;
  logic [31:0] icache_w_instr_o;
  logic        refill_done_o;
  logic        err_o;

  icache_refill_ctrl #(
    .icache_tag_width_p           (6),
    .icache_entries_p             (16),
    .icache_block_size_in_words_p (4)
  ) dut (
    .clk_i            (clk),
    .reset_i          (reset_i),
    .miss_v_i         (miss_v_i),
    .miss_pc_i        (miss_pc_i),
    .miss_ready_o     (miss_ready_o),
    .req_v_o          (req_v_o),
    .req_addr_o       (req_addr_o),
    .req_ready_i      (req_ready_i),
    .resp_v_i         (resp_v_i),
    .resp_offset_i    (resp_offset_i),
    .resp_data_i      (resp_data_i),
    .icache_v_o       (icache_v_o),
    .icache_w_pc_o    (icache_w_pc_o),
    .icache_w_instr_o (icache_w_instr_o),
    .refill_done_o    (refill_done_o),
    .err_o            (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        mv;
    logic [9:0]  mpc;
    logic        rdy;
    logic        rv;
    logic [1:0]  ro;
    logic [31:0] rd;
    logic        e_mr;
    logic        e_rv;
    logic [9:0]  e_ra;
    logic        e_iv;
    logic [9:0]  e_wpc;
    logic [31:0] e_wd;
    logic        e_dn;
  } vec_t;

  vec_t        tbl[$];
  logic [1:0]  ro_q[$];
  logic [31:0] rd_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;

  // Expected request address for the k-th request of the block holding pc.
  function automatic logic [9:0] ra(input logic [9:0] pc, input int k);
    logic [9:0] b;
    b = {pc[9:2], 2'b00};
`ifdef ICACHE_REFILL_CRITICAL_WORD_FIRST_EN
    return b + 10'((int'(pc[1:0]) + k) % 4);
`else
    return b + 10'(k);
`endif
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic add(input logic mv, input logic [9:0] mpc, input logic rdy, input logic rv,
                     input logic [1:0] ro, input logic [31:0] rd, input logic e_mr,
                     input logic e_rv, input logic [9:0] e_ra, input logic e_iv,
                     input logic [9:0] e_wpc, input logic [31:0] e_wd, input logic e_dn);
    vec_t v;
    v.mv = mv; v.mpc = mpc; v.rdy = rdy; v.rv = rv; v.ro = ro; v.rd = rd;
    v.e_mr = e_mr; v.e_rv = e_rv; v.e_ra = e_ra; v.e_iv = e_iv;
    v.e_wpc = e_wpc; v.e_wd = e_wd; v.e_dn = e_dn;
    tbl.push_back(v);
  endtask

  // Accept a miss and let all four requests go out with ready held high.
  task automatic issue_all(input logic [9:0] pc);
    int n;
    n = 0;
    chk("issue_idle", miss_ready_o, 1);
    miss_v_i = 1'b1; miss_pc_i = pc;
    @(negedge clk);
    miss_v_i = 1'b0; req_ready_i = 1'b1;
    for (int c = 0; c < 10 && n < 4; c++) begin
      if (req_v_o) begin
        chk($sformatf("issue_addr%0d", n), req_addr_o, ra(pc, n));
        n++;
      end
      @(negedge clk);
    end
    req_ready_i = 1'b0;
    chk("issue_count", n, 4);
  endtask

  // Drive the queued responses one per cycle and check the in-order write stream.
  task automatic respond(input logic [9:0] pc, input logic [31:0] dbase);
    int nw, dn;
    nw = 0; dn = 0;
    for (int c = 0; c < 14; c++) begin
      if (icache_v_o) begin
        if (nw < 4) begin
          chk($sformatf("wr_pc%0d", nw), icache_w_pc_o, {pc[9:2], 2'b00} + 10'(nw));
          chk($sformatf("wr_data%0d", nw), icache_w_instr_o, dbase + 32'(nw));
        end
        if (refill_done_o) begin
          chk("done_on_last", nw, 3);
          dn++;
        end
        nw++;
      end
      if (c < ro_q.size()) begin
        resp_v_i = 1'b1; resp_offset_i = ro_q[c]; resp_data_i = rd_q[c];
      end else begin
        resp_v_i = 1'b0;
      end
      @(negedge clk);
    end
    resp_v_i = 1'b0;
    chk("write_count", nw, 4);
    chk("done_count", dn, 1);
    chk("idle_after", miss_ready_o, 1);
  endtask

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int nreq;
    reset_i = 1'b0; miss_v_i = 1'b0; miss_pc_i = '0; req_ready_i = 1'b0;
    resp_v_i = 1'b0; resp_offset_i = '0; resp_data_i = '0;
    #1;
    chk("rst_miss_ready", miss_ready_o, 1);
    chk("rst_req_v", req_v_o, 0);
    chk("rst_icache_v", icache_v_o, 0);
    chk("rst_done", refill_done_o, 0);
    chk("rst_err", err_o, 0);
    repeat (2) @(negedge clk);
    reset_i = 1'b1;

    // In-order refill of block 0x0A4 (miss 0x0A6).
    add(1, 10'h0A6, 0, 0, 0, 0,            1, 0, 0, 0, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0,                  0, 1, ra(10'h0A6, 0), 0, 0, 0, 0);
    add(0, 0, 1, 1, 0, 32'hA000_0000,      0, 1, ra(10'h0A6, 1), 0, 0, 0, 0);
    add(0, 0, 1, 1, 1, 32'hA000_0001,      0, 1, ra(10'h0A6, 2), 1, 10'h0A4, 32'hA000_0000, 0);
    add(0, 0, 1, 1, 2, 32'hA000_0002,      0, 1, ra(10'h0A6, 3), 1, 10'h0A5, 32'hA000_0001, 0);
    add(0, 0, 0, 1, 3, 32'hA000_0003,      0, 0, 0, 1, 10'h0A6, 32'hA000_0002, 0);
    add(0, 0, 0, 0, 0, 0,                  0, 0, 0, 1, 10'h0A7, 32'hA000_0003, 1);
    // Reverse-order refill of block 0x150 (miss 0x153).
    add(1, 10'h153, 0, 0, 0, 0,            1, 0, 0, 0, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0,                  0, 1, ra(10'h153, 0), 0, 0, 0, 0);
    add(0, 0, 1, 1, 3, 32'hB000_0003,      0, 1, ra(10'h153, 1), 0, 0, 0, 0);
    add(0, 0, 1, 1, 2, 32'hB000_0002,      0, 1, ra(10'h153, 2), 0, 0, 0, 0);
    add(0, 0, 1, 1, 1, 32'hB000_0001,      0, 1, ra(10'h153, 3), 0, 0, 0, 0);
    add(0, 0, 0, 1, 0, 32'hB000_0000,      0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0,                  0, 0, 0, 1, 10'h150, 32'hB000_0000, 0);
    add(0, 0, 0, 0, 0, 0,                  0, 0, 0, 1, 10'h151, 32'hB000_0001, 0);
    add(0, 0, 0, 0, 0, 0,                  0, 0, 0, 1, 10'h152, 32'hB000_0002, 0);
    add(0, 0, 0, 0, 0, 0,                  0, 0, 0, 1, 10'h153, 32'hB000_0003, 1);
    add(0, 0, 0, 0, 0, 0,                  1, 0, 0, 0, 0, 0, 0);

    foreach (tbl[i]) begin
      vec_t v;
      v = tbl[i];
      chk($sformatf("row%0d_miss_ready", i), miss_ready_o, v.e_mr);
      chk($sformatf("row%0d_req_v", i), req_v_o, v.e_rv);
      if (v.e_rv) chk($sformatf("row%0d_req_addr", i), req_addr_o, v.e_ra);
      chk($sformatf("row%0d_icache_v", i), icache_v_o, v.e_iv);
      if (v.e_iv) begin
        chk($sformatf("row%0d_w_pc", i), icache_w_pc_o, v.e_wpc);
        chk($sformatf("row%0d_w_instr", i), icache_w_instr_o, v.e_wd);
      end
      chk($sformatf("row%0d_done", i), refill_done_o, v.e_dn);
      chk($sformatf("row%0d_err", i), err_o, 0);
      miss_v_i = v.mv; miss_pc_i = v.mpc; req_ready_i = v.rdy;
      resp_v_i = v.rv; resp_offset_i = v.ro; resp_data_i = v.rd;
      @(negedge clk);
    end
    miss_v_i = 1'b0; req_ready_i = 1'b0; resp_v_i = 1'b0;

    // Back-pressure: ready alternates, each stalled address must hold.
    miss_v_i = 1'b1; miss_pc_i = 10'h0C1;
    @(negedge clk);
    miss_v_i = 1'b0;
    nreq = 0;
    for (int c = 0; c < 12; c++) begin
      req_ready_i = (c % 2 == 0);
      if (req_v_o) begin
        chk($sformatf("bp_addr_c%0d", c), req_addr_o, ra(10'h0C1, nreq));
        if (req_ready_i) nreq++;
      end
      @(negedge clk);
    end
    req_ready_i = 1'b0;
    chk("bp_req_count", nreq, 4);
    chk("bp_req_v_off", req_v_o, 0);
    ro_q = '{2'd0, 2'd1, 2'd2, 2'd3};
    rd_q = '{32'hC000_0000, 32'hC000_0001, 32'hC000_0002, 32'hC000_0003};
    respond(10'h0C1, 32'hC000_0000);

    // Errors: response while idle, then a duplicate offset 1 carrying bogus data.
    resp_v_i = 1'b1; resp_offset_i = 2'd2; resp_data_i = 32'h1234_5678;
    @(negedge clk);
    resp_v_i = 1'b0;
    chk("err_idle_resp", err_o, 1);
    chk("err_stays_idle", miss_ready_o, 1);
    issue_all(10'h2B2);
    ro_q = '{2'd1, 2'd1, 2'd0, 2'd2, 2'd3};
    rd_q = '{32'hE000_0001, 32'hDEAD_BEEF, 32'hE000_0000, 32'hE000_0002, 32'hE000_0003};
    respond(10'h2B2, 32'hE000_0000);
    chk("err_sticky", err_o, 1);

    // Reset after two writes, then a fresh refill.
    issue_all(10'h3C5);
    resp_v_i = 1'b1; resp_offset_i = 2'd0; resp_data_i = 32'h3000_0000;
    @(negedge clk);
    resp_offset_i = 2'd1; resp_data_i = 32'h3000_0001;
    @(negedge clk);
    resp_offset_i = 2'd2; resp_data_i = 32'h3000_0002;
    @(negedge clk);
    resp_v_i = 1'b0;
    chk("pre_rst_icache_v", icache_v_o, 1);
    chk("pre_rst_w_pc", icache_w_pc_o, 10'h3C6);
    reset_i = 1'b0;
    #1;
    chk("mid_rst_miss_ready", miss_ready_o, 1);
    chk("mid_rst_req_v", req_v_o, 0);
    chk("mid_rst_icache_v", icache_v_o, 0);
    chk("mid_rst_done", refill_done_o, 0);
    chk("mid_rst_err", err_o, 0);
    repeat (2) @(negedge clk);
    reset_i = 1'b1;
    @(negedge clk);
    issue_all(10'h0E7);
    ro_q = '{2'd0, 2'd1, 2'd2, 2'd3};
    rd_q = '{32'h7000_0000, 32'h7000_0001, 32'h7000_0002, 32'h7000_0003};
    respond(10'h0E7, 32'h7000_0000);
    chk("post_rst_err", err_o, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
